// File: rtl/sequence_timing_unit.sv
// Sequence timing unit of a basic accumulator computer: the T0..T15 sequence
// counter, the D0..D7 opcode decode, and the I, R, IEN and S (run) control flags.
module sequence_timing_unit (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [15:0] IR,
    input  logic        SC_CLR,
    input  logic        FGI,
    input  logic        FGO,
    input  logic        START,
    output logic [15:0] TIME_SIGNAL,
    output logic [7:0]  DEC_SIGNAL,
    output logic        INDIRECT_BIT,
    output logic        INTERRUPT_R,
    output logic        IEN,
    output logic        RUNNING
);

    logic [3:0]  sc;
    logic        i_flag;
    logic        r_flag;
    logic        ien_flag;
    logic        s_flag;

    logic [15:0] t_dec;
    logic [7:0]  d_dec;
    logic        exec_x;
    logic        int_clr;
    logic        int_set;
    logic        ion_op;
    logic        iof_op;
    logic        hlt_op;

    logic [3:0]  sc_nxt;
    logic        i_nxt;
    logic        r_nxt;
    logic        ien_nxt;
    logic        s_nxt;

    assign t_dec = 16'h0001 << sc;
    assign d_dec = 8'h01 << IR[14:12];

    // Register/IO-reference execute slot and the instruction bits it acts on
    assign exec_x  = d_dec[7] & t_dec[3] & ~r_flag & s_flag;
    assign ion_op  = exec_x & IR[15] & IR[7];
    assign iof_op  = exec_x & IR[15] & IR[6];
    assign hlt_op  = exec_x & ~IR[15] & IR[0];

    // Interrupt cycle ends at T2; it may only begin once T0..T2 of the
    // current instruction have been used for fetch/decode.
    assign int_clr = r_flag & t_dec[2] & s_flag;
    assign int_set = s_flag & (sc > 4'd2) & ien_flag & (FGI | FGO);

    always_comb begin
        sc_nxt  = sc;
        i_nxt   = i_flag;
        r_nxt   = r_flag;
        ien_nxt = ien_flag;
        s_nxt   = s_flag;

        if (s_flag) begin
            if (SC_CLR || int_clr) begin
                sc_nxt = 4'd0;
            end else begin
                sc_nxt = sc + 4'd1;
            end
        end else if (SC_CLR) begin
            sc_nxt = 4'd0;
        end

        if (t_dec[2] && !r_flag && s_flag) begin
            i_nxt = IR[15];
        end

        if (int_clr) begin
            r_nxt = 1'b0;
        end else if (int_set) begin
            r_nxt = 1'b1;
        end

        // IOF beats ION within one instruction; ION beats the interrupt-cycle clear
        if (iof_op) begin
            ien_nxt = 1'b0;
        end else if (ion_op) begin
            ien_nxt = 1'b1;
        end else if (int_clr) begin
            ien_nxt = 1'b0;
        end

        if (START) begin
            s_nxt = 1'b1;
        end else if (hlt_op) begin
            s_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sc       <= 4'd0;
            i_flag   <= 1'b0;
            r_flag   <= 1'b0;
            ien_flag <= 1'b0;
            s_flag   <= 1'b1;
        end else begin
            sc       <= sc_nxt;
            i_flag   <= i_nxt;
            r_flag   <= r_nxt;
            ien_flag <= ien_nxt;
            s_flag   <= s_nxt;
        end
    end

    assign TIME_SIGNAL  = t_dec;
    assign DEC_SIGNAL   = d_dec;
    assign INDIRECT_BIT = i_flag;
    assign INTERRUPT_R  = r_flag;
    assign IEN          = ien_flag;
    assign RUNNING      = s_flag;

    // The execute slot requires R = 0, so it can never meet the end of an interrupt cycle
    a_no_ion_during_int_clr : assert property (
        @(posedge CLK) disable iff (!RESET_N) !(exec_x && int_clr)
    );

endmodule

// File: tb/tb_sequence_timing_unit.sv
// Directed bench for sequence_timing_unit: counter walk/wrap, indirect load,
// ION/IOF, interrupt cycle, halt/start and asynchronous reset mid-cycle.
module tb_sequence_timing_unit;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic [15:0] IR = 16'h0000;
    logic        SC_CLR = 1'b0;
    logic        FGI = 1'b0;
    logic        FGO = 1'b0;
    logic        START = 1'b0;
    logic [15:0] TIME_SIGNAL;
    logic [7:0]  DEC_SIGNAL;
    logic        INDIRECT_BIT;
    logic        INTERRUPT_R;
    logic        IEN;
    logic        RUNNING;

    int checks = 0;
    int errors = 0;

    sequence_timing_unit dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .IR           (IR),
        .SC_CLR       (SC_CLR),
        .FGI          (FGI),
        .FGO          (FGO),
        .START        (START),
        .TIME_SIGNAL  (TIME_SIGNAL),
        .DEC_SIGNAL   (DEC_SIGNAL),
        .INDIRECT_BIT (INDIRECT_BIT),
        .INTERRUPT_R  (INTERRUPT_R),
        .IEN          (IEN),
        .RUNNING      (RUNNING)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before driving/sampling
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        // Reset state
        #1 RESET_N = 1'b0;
        #1;
        chk("rst_time", TIME_SIGNAL, 16'h0001);
        chk("rst_run",  {15'd0, RUNNING}, 16'd1);
        chk("rst_ien",  {15'd0, IEN}, 16'd0);
        chk("rst_r",    {15'd0, INTERRUPT_R}, 16'd0);
        chk("rst_i",    {15'd0, INDIRECT_BIT}, 16'd0);
        chk("rst_dec0", {8'd0, DEC_SIGNAL}, 16'h0001);
        IR = 16'h3000;
        #1;
        chk("rst_dec3", {8'd0, DEC_SIGNAL}, 16'h0008);
        IR = 16'h0000;
        step(2);
        chk("rst_hold", TIME_SIGNAL, 16'h0001);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Free-running walk T1..T15 then wrap to T0
        for (int k = 1; k <= 16; k++) begin
            step(1);
            chk($sformatf("walk_t%0d", k % 16), TIME_SIGNAL, 16'h0001 << (k % 16));
        end

        // Indirect bit loaded at T2, SC_CLR at T5 returns to T0
        IR = 16'h8000;
        #1;
        chk("dec_d0", {8'd0, DEC_SIGNAL}, 16'h0001);
        step(2);
        chk("ind_pre", {15'd0, INDIRECT_BIT}, 16'd0);
        step(1);
        chk("ind_t3", TIME_SIGNAL, 16'h0008);
        chk("ind_set", {15'd0, INDIRECT_BIT}, 16'd1);
        step(2);
        chk("ind_t5", TIME_SIGNAL, 16'h0020);
        SC_CLR = 1'b1;
        step(1);
        SC_CLR = 1'b0;
        chk("clr_t0", TIME_SIGNAL, 16'h0001);
        IR = 16'h0000;

        // ION at T3, FGI at T4, interrupt cycle T0..T2
        step(3);
        chk("ion_t3", TIME_SIGNAL, 16'h0008);
        chk("ind_reload", {15'd0, INDIRECT_BIT}, 16'd0);
        IR = 16'hF080;
        #1;
        chk("dec_d7", {8'd0, DEC_SIGNAL}, 16'h0080);
        step(1);
        chk("ion_ien", {15'd0, IEN}, 16'd1);
        chk("ion_r0", {15'd0, INTERRUPT_R}, 16'd0);
        IR = 16'h0000;
        FGI = 1'b1;
        step(1);
        FGI = 1'b0;
        chk("int_r1", {15'd0, INTERRUPT_R}, 16'd1);
        chk("int_t5", TIME_SIGNAL, 16'h0020);
        step(11);
        chk("int_rt0", TIME_SIGNAL, 16'h0001);
        chk("int_rt0_r", {15'd0, INTERRUPT_R}, 16'd1);
        step(2);
        chk("int_rt2", TIME_SIGNAL, 16'h0004);
        step(1);
        chk("int_end_r", {15'd0, INTERRUPT_R}, 16'd0);
        chk("int_end_ien", {15'd0, IEN}, 16'd0);
        chk("int_end_t0", TIME_SIGNAL, 16'h0001);

        // IOF beats ION when both bits set
        step(3);
        IR = 16'hF080;
        step(1);
        IR = 16'h0000;
        chk("iof_pre_ien", {15'd0, IEN}, 16'd1);
        step(15);
        chk("iof_t3", TIME_SIGNAL, 16'h0008);
        IR = 16'hF0C0;
        step(1);
        IR = 16'h0000;
        chk("iof_ien", {15'd0, IEN}, 16'd0);
        chk("iof_t4", TIME_SIGNAL, 16'h0010);

        // HLT: SC advances to 4 then freezes; START resumes 4 -> 5
        step(15);
        chk("hlt_t3", TIME_SIGNAL, 16'h0008);
        IR = 16'h7001;
        step(1);
        IR = 16'h0000;
        chk("hlt_run", {15'd0, RUNNING}, 16'd0);
        chk("hlt_t4", TIME_SIGNAL, 16'h0010);
        step(3);
        chk("hlt_frozen", TIME_SIGNAL, 16'h0010);
        START = 1'b1;
        step(1);
        START = 1'b0;
        chk("start_run", {15'd0, RUNNING}, 16'd1);
        chk("start_t4", TIME_SIGNAL, 16'h0010);
        step(1);
        chk("resume_t5", TIME_SIGNAL, 16'h0020);

        // START wins over simultaneous HLT
        step(14);
        chk("sw_t3", TIME_SIGNAL, 16'h0008);
        IR = 16'h7001;
        START = 1'b1;
        step(1);
        START = 1'b0;
        IR = 16'h0000;
        chk("sw_run", {15'd0, RUNNING}, 16'd1);
        chk("sw_t4", TIME_SIGNAL, 16'h0010);

        // SC_CLR still clears SC while halted
        step(15);
        IR = 16'h7001;
        step(1);
        IR = 16'h0000;
        chk("hclr_halt", {15'd0, RUNNING}, 16'd0);
        SC_CLR = 1'b1;
        step(1);
        SC_CLR = 1'b0;
        chk("hclr_t0", TIME_SIGNAL, 16'h0001);
        step(1);
        chk("hclr_hold", TIME_SIGNAL, 16'h0001);
        START = 1'b1;
        step(1);
        START = 1'b0;

        // Reset asserted at T6 of an interrupt-pending instruction with IEN = 1
        step(3);
        IR = 16'hF080;
        step(1);
        IR = 16'h0000;
        FGO = 1'b1;
        step(1);
        FGO = 1'b0;
        step(1);
        chk("pre_rst_t6", TIME_SIGNAL, 16'h0040);
        chk("pre_rst_r", {15'd0, INTERRUPT_R}, 16'd1);
        chk("pre_rst_ien", {15'd0, IEN}, 16'd1);
        RESET_N = 1'b0;
        #2;
        chk("arst_t0", TIME_SIGNAL, 16'h0001);
        chk("arst_r", {15'd0, INTERRUPT_R}, 16'd0);
        chk("arst_ien", {15'd0, IEN}, 16'd0);
        chk("arst_run", {15'd0, RUNNING}, 16'd1);
        @(negedge CLK);
        RESET_N = 1'b1;
        step(1);
        chk("post_rst_t1", TIME_SIGNAL, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
